// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register offsets, bus FSM
// states and the byte-strobe expansion helper.
package gpio_pkg;

  localparam logic [4:0] GPIO_OUT        = 5'h00;
  localparam logic [4:0] GPIO_DIR        = 5'h04;
  localparam logic [4:0] GPIO_IN         = 5'h08;
  localparam logic [4:0] GPIO_RISE_EN    = 5'h0C;
  localparam logic [4:0] GPIO_FALL_EN    = 5'h10;
  localparam logic [4:0] GPIO_IRQ_STATUS = 5'h14;
  localparam logic [4:0] GPIO_OUT_SET    = 5'h18;
  localparam logic [4:0] GPIO_OUT_CLR    = 5'h1C;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Pad input synchroniser followed by a history flop; produces the settled
// pin value and single-cycle rise/fall indications.
module gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this array is a flop chain, not a RAM, so every stage is reset
      // to keep spurious edges from firing right after reset.
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      hist_q <= '0;
    end else begin
      stage_q[0] <= pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      hist_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~hist_q;
  assign fall_o = ~sync_o & hist_q;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller on the PicoRV32 native bus: output/direction registers,
// atomic set/clear, synchronised inputs and W1C edge interrupts.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_rdata,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oe,
  output logic             irq
);

  bus_state_e       state_q, state_d;
  logic             req_seen_q, req_seen_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] pin_sync, pin_rise, pin_fall, edge_evt;
  logic             sel, accept, is_write;
  logic [4:0]       reg_off;
  logic [31:0]      mask32, wbits32;
  logic [WIDTH-1:0] wmask, wbits;
  logic             unused_bits;

  gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .pin_i (io_in),
    .sync_o(pin_sync),
    .rise_o(pin_rise),
    .fall_o(pin_fall)
  );

  assign sel      = (mem_addr[31:5] == BASE_ADDR[31:5]);
  assign reg_off  = {mem_addr[4:2], 2'b00};
  assign is_write = |mem_wstrb;
  // req_seen_q blocks a master that keeps mem_valid high after its ready pulse.
  assign accept   = (state_q == ST_IDLE) && mem_valid && sel && !req_seen_q;

  assign mask32      = strb_mask(mem_wstrb);
  assign wbits32     = mem_wdata & mask32;
  assign wmask       = mask32[WIDTH-1:0];
  assign wbits       = wbits32[WIDTH-1:0];
  assign unused_bits = ^{mask32, wbits32, mem_addr[1:0]};

  assign edge_evt = (pin_rise & rise_en_q) | (pin_fall & fall_en_q);

  always_comb begin
    // NOTE: combinational logic uses blocking '=' with every output given a
    // default first, so no path can infer a latch; flops use '<=' only.
    state_d    = state_q;
    req_seen_d = mem_valid & (req_seen_q | accept);
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;
    rdata_d   = '0;
    if (accept && is_write) begin
      case (reg_off)
        GPIO_OUT:        out_d     = (out_q & ~wmask) | wbits;
        GPIO_DIR:        dir_d     = (dir_q & ~wmask) | wbits;
        GPIO_RISE_EN:    rise_en_d = (rise_en_q & ~wmask) | wbits;
        GPIO_FALL_EN:    fall_en_d = (fall_en_q & ~wmask) | wbits;
        GPIO_IRQ_STATUS: status_d  = status_q & ~wbits;
        GPIO_OUT_SET:    out_d     = out_q | wbits;
        GPIO_OUT_CLR:    out_d     = out_q & ~wbits;
        default:         ;
      endcase
    end else if (accept) begin
      case (reg_off)
        GPIO_OUT:        rdata_d = 32'(out_q);
        GPIO_DIR:        rdata_d = 32'(dir_q);
        GPIO_IN:         rdata_d = 32'(pin_sync);
        GPIO_RISE_EN:    rdata_d = 32'(rise_en_q);
        GPIO_FALL_EN:    rdata_d = 32'(fall_en_q);
        GPIO_IRQ_STATUS: rdata_d = 32'(status_q);
        default:         rdata_d = '0;
      endcase
    end
    // A new edge is applied after the W1C so it wins a same-cycle race.
    status_d = status_d | edge_evt;
    irq_d    = |status_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_seen_q <= 1'b0;
      rdata_q    <= '0;
      out_q      <= '0;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      rdata_q    <= rdata_d;
      out_q      <= out_d;
      dir_q      <= dir_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      irq_q      <= irq_d;
    end
  end

  assign mem_ready = (state_q == ST_ACK);
  assign mem_rdata = rdata_q;
  assign io_out    = out_q;
  assign io_oe     = dir_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl (WIDTH=16): register table plus hand-written
// handshake, edge-interrupt, W1C race and reset-in-ACK sequences.
module tb_gpio_ctrl;
  import gpio_pkg::*;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic [15:0] io_oe;
  logic        irq;

  int nvec  = 0;
  int nfail = 0;

  gpio_ctrl #(
    .WIDTH      (16),
    .BASE_ADDR  (BASE),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oe    (io_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_write;
    logic [4:0]  off;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [15:0] exp_out;
    logic [15:0] exp_oe;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns at the negedge of the ready cycle, with mem_valid already dropped.
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata);
    logic ok;
    ok    = 1'b0;
    rdata = '0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        ok    = 1'b1;
        rdata = mem_rdata;
        break;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    if (!ok) begin
      nvec++;
      nfail++;
      $display("FAIL bus_timeout: no mem_ready for addr %h", addr);
    end
  endtask

  task automatic reg_wr(input logic [4:0] off, input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] dummy;
    bus_xfer(BASE | {27'h0, off}, wdata, strb, dummy);
  endtask

  task automatic reg_rd_check(input string name, input logic [4:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    bus_xfer(BASE | {27'h0, off}, 32'h0, 4'b0000, rd);
    check(name, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    int          pulses;
    int          first_idx;

    vecs[0]  = '{1'b0, GPIO_OUT,        32'h0,         4'h0, 16'h0,    16'h0,    32'h0};
    vecs[1]  = '{1'b0, GPIO_DIR,        32'h0,         4'h0, 16'h0,    16'h0,    32'h0};
    vecs[2]  = '{1'b0, GPIO_IN,         32'h0,         4'h0, 16'h0,    16'h0,    32'h0};
    vecs[3]  = '{1'b0, GPIO_RISE_EN,    32'h0,         4'h0, 16'h0,    16'h0,    32'h0};
    vecs[4]  = '{1'b0, GPIO_FALL_EN,    32'h0,         4'h0, 16'h0,    16'h0,    32'h0};
    vecs[5]  = '{1'b0, GPIO_IRQ_STATUS, 32'h0,         4'h0, 16'h0,    16'h0,    32'h0};
    vecs[6]  = '{1'b0, GPIO_OUT_SET,    32'h0,         4'h0, 16'h0,    16'h0,    32'h0};
    vecs[7]  = '{1'b0, GPIO_OUT_CLR,    32'h0,         4'h0, 16'h0,    16'h0,    32'h0};
    vecs[8]  = '{1'b1, GPIO_OUT,        32'h0000_ABCD, 4'h1, 16'h00CD, 16'h0000, 32'h0};
    vecs[9]  = '{1'b1, GPIO_OUT_SET,    32'h0000_0F00, 4'hF, 16'h0FCD, 16'h0000, 32'h0};
    vecs[10] = '{1'b1, GPIO_OUT_CLR,    32'h0000_00C0, 4'hF, 16'h0F0D, 16'h0000, 32'h0};
    vecs[11] = '{1'b0, GPIO_OUT,        32'h0,         4'h0, 16'h0,    16'h0,    32'h0000_0F0D};
    vecs[12] = '{1'b0, GPIO_OUT_SET,    32'h0,         4'h0, 16'h0,    16'h0,    32'h0};
    vecs[13] = '{1'b1, GPIO_DIR,        32'hFFFF_A5A5, 4'hF, 16'h0F0D, 16'hA5A5, 32'h0};
    vecs[14] = '{1'b0, GPIO_DIR,        32'h0,         4'h0, 16'h0,    16'h0,    32'h0000_A5A5};
    vecs[15] = '{1'b1, GPIO_DIR,        32'h0000_1234, 4'h2, 16'h0F0D, 16'h12A5, 32'h0};
    vecs[16] = '{1'b1, GPIO_OUT_SET,    32'h0000_FFFF, 4'h1, 16'h0FFF, 16'h12A5, 32'h0};
    vecs[17] = '{1'b1, GPIO_OUT_CLR,    32'h0000_FFFF, 4'h2, 16'h00FF, 16'h12A5, 32'h0};
    vecs[18] = '{1'b1, GPIO_IN,         32'h0000_FFFF, 4'hF, 16'h00FF, 16'h12A5, 32'h0};
    vecs[19] = '{1'b0, GPIO_IN,         32'h0,         4'h0, 16'h0,    16'h0,    32'h0};
    vecs[20] = '{1'b1, GPIO_RISE_EN,    32'hFFFF_FFFF, 4'hF, 16'h00FF, 16'h12A5, 32'h0};
    vecs[21] = '{1'b0, GPIO_RISE_EN,    32'h0,         4'h0, 16'h0,    16'h0,    32'h0000_FFFF};
    vecs[22] = '{1'b1, GPIO_RISE_EN,    32'h0000_0000, 4'hF, 16'h00FF, 16'h12A5, 32'h0};
    vecs[23] = '{1'b1, GPIO_DIR,        32'h0000_0000, 4'hF, 16'h00FF, 16'h0000, 32'h0};

    rst       = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    io_in     = '0;
    repeat (5) @(negedge clk);
    check("reset io_out",    {16'h0, io_out}, 32'h0);
    check("reset io_oe",     {16'h0, io_oe},  32'h0);
    check("reset irq",       {31'h0, irq},    32'h0);
    check("reset mem_ready", {31'h0, mem_ready}, 32'h0);
    check("reset mem_rdata", mem_rdata,       32'h0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      bus_xfer(BASE | {27'h0, vecs[i].off}, vecs[i].wdata, vecs[i].strb, rd);
      if (vecs[i].is_write) begin
        check($sformatf("vec%0d io_out", i), {16'h0, io_out}, {16'h0, vecs[i].exp_out});
        check($sformatf("vec%0d io_oe", i),  {16'h0, io_oe},  {16'h0, vecs[i].exp_oe});
      end else begin
        check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      end
    end

    // Handshake: valid held for four cycles yields one ready, on the 2nd cycle.
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE | {27'h0, GPIO_OUT};
    mem_wstrb = 4'b0000;
    pulses    = 0;
    first_idx = -1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
    mem_valid = 1'b0;
    check("held valid pulses", 32'(pulses), 32'd1);
    check("held valid first",  32'(first_idx), 32'd1);

    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h0400_0000;
    pulses    = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_ready) pulses++;
    end
    mem_valid = 1'b0;
    check("unselected pulses", 32'(pulses), 32'd0);

    // Edge interrupts.
    reg_wr(GPIO_RISE_EN, 32'h01, 4'hF);
    reg_wr(GPIO_FALL_EN, 32'h02, 4'hF);
    io_in[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("irq before sync+1", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("irq at sync+1", {31'h0, irq}, 32'h1);
    reg_rd_check("status pin0 rise", GPIO_IRQ_STATUS, 32'h01);
    reg_rd_check("IN pin0", GPIO_IN, 32'h01);

    io_in[1] = 1'b1;
    repeat (5) @(negedge clk);
    reg_rd_check("status pin1 rise", GPIO_IRQ_STATUS, 32'h01);
    io_in[1] = 1'b0;
    repeat (5) @(negedge clk);
    reg_rd_check("status pin1 fall", GPIO_IRQ_STATUS, 32'h03);

    io_in[2] = 1'b1;
    repeat (5) @(negedge clk);
    io_in[2] = 1'b0;
    repeat (5) @(negedge clk);
    reg_rd_check("status pin2 toggle", GPIO_IRQ_STATUS, 32'h03);

    reg_wr(GPIO_IRQ_STATUS, 32'h02, 4'hF);
    reg_rd_check("status after w1c bit1", GPIO_IRQ_STATUS, 32'h01);

    // W1C on bit 0 lands on the same edge as a new rise on pin 0.
    io_in[0] = 1'b0;
    repeat (5) @(negedge clk);
    reg_rd_check("status before race", GPIO_IRQ_STATUS, 32'h01);
    io_in[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE | {27'h0, GPIO_IRQ_STATUS};
    mem_wdata = 32'h01;
    mem_wstrb = 4'hF;
    @(negedge clk);
    check("race ready", {31'h0, mem_ready}, 32'h1);
    check("race irq ack", {31'h0, irq}, 32'h1);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(negedge clk);
    check("race irq after", {31'h0, irq}, 32'h1);
    reg_rd_check("race status", GPIO_IRQ_STATUS, 32'h01);

    reg_wr(GPIO_RISE_EN, 32'h00, 4'hF);
    reg_rd_check("status after enable clear", GPIO_IRQ_STATUS, 32'h01);
    reg_wr(GPIO_IRQ_STATUS, 32'hFF, 4'h2);
    reg_rd_check("w1c wrong byte", GPIO_IRQ_STATUS, 32'h01);
    reg_wr(GPIO_IRQ_STATUS, 32'h01, 4'hF);
    @(negedge clk);
    check("irq after w1c", {31'h0, irq}, 32'h0);
    reg_rd_check("status cleared", GPIO_IRQ_STATUS, 32'h00);

    // IN follows pins with every pin driven.
    reg_wr(GPIO_DIR, 32'hFFFF, 4'hF);
    io_in = 16'h5A5A;
    repeat (3) @(negedge clk);
    reg_rd_check("IN with DIR set", GPIO_IN, 32'h5A5A);

    // Reset asserted in the ACK cycle of a DIR write.
    reg_wr(GPIO_DIR, 32'h0000, 4'hF);
    reg_wr(GPIO_OUT, 32'h1111, 4'hF);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE | {27'h0, GPIO_DIR};
    mem_wdata = 32'hFFFF;
    mem_wstrb = 4'hF;
    @(negedge clk);
    check("rst-ack ready", {31'h0, mem_ready}, 32'h1);
    rst       = 1'b1;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(negedge clk);
    check("rst-ack ready after", {31'h0, mem_ready}, 32'h0);
    check("rst-ack io_oe", {16'h0, io_oe}, 32'h0);
    check("rst-ack io_out", {16'h0, io_out}, 32'h0);
    rst = 1'b0;
    reg_rd_check("rst-ack DIR read", GPIO_DIR, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
